// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t : controller states
//   W_DEF   : default operand width
//   CNT_W   : iteration counter width for W_DEF
//   cnt_w() : counter width for an arbitrary operand width
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEF = 8;
  localparam int CNT_W = $clog2(W_DEF);

  // The counter runs W-1 down to 0, so clog2(W) bits suffice.
  // Floor at 1 bit so a degenerate width still elaborates.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration (purely combinational).
//   r_in    : partial remainder from the previous iteration (W+1 bits)
//   bit_in  : next dividend bit, MSB first
//   divisor : W-bit divisor
//   r_out   : partial remainder after the trial subtraction
//   q_bit   : quotient bit produced by this iteration
module seq_restoring_divider_div_step
  import seq_restoring_divider_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   r_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   r_out,
  output logic         q_bit
);

  logic [W:0] t;
  logic [W:0] d;

  // r_in is always below the divisor, so its top bit is zero and
  // shifting in one bit cannot exceed W+1 bits.
  assign t = {r_in[W-1:0], bit_in};
  assign d = {1'b0, divisor};

  assign q_bit = (t >= d);
  assign r_out = q_bit ? (t - d) : t;

  logic unused_rmsb;
  assign unused_rmsb = r_in[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, single operation in flight.
//   clk, rst              : clock, async active-high reset
//   in_valid / in_ready   : request handshake (ready only in IDLE)
//   dividend, divisor     : operands, sampled on accept
//   out_valid / out_ready : result handshake (valid only in DONE)
//   quotient, remainder   : result, held until the next result
//   div_by_zero, overflow : error flags for the current result
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = cnt_w(W);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W:0]    r;    // partial remainder
  logic [W-1:0]  lo;   // remaining dividend bits, consumed MSB first
  logic [W-1:0]  q;    // quotient bits collected so far
  logic [W-1:0]  dvs;  // latched divisor

  logic [W:0]    r_next;
  logic          qbit;
  logic [W-1:0]  q_next;
  logic [W-1:0]  hi;

  assign hi     = dividend[2*W-1:W];
  assign q_next = {q[W-2:0], qbit};

  seq_restoring_divider_div_step #(.W(W)) u_step (
    .r_in    (r),
    .bit_in  (lo[W-1]),
    .divisor (dvs),
    .r_out   (r_next),
    .q_bit   (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      r           <= '0;
      lo          <= '0;
      q           <= '0;
      dvs         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            dvs      <= divisor;
            if (divisor == '0) begin
              state       <= DONE;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= '1;
              remainder   <= dividend[W-1:0];
            end else if (hi >= divisor) begin
              // Quotient would need more than W bits.
              state       <= DONE;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[W-1:0];
            end else begin
              state <= CALC;
              r     <= {1'b0, hi};
              lo    <= dividend[W-1:0];
              q     <= '0;
              cnt   <= CW'(W - 1);
            end
          end
        end

        CALC: begin
          r  <= r_next;
          lo <= lo << 1;
          q  <= q_next;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[W-1:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        DONE: begin
          // Error results enter DONE straight from IDLE with their
          // outputs already loaded; valid follows one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
